// File: rtl/watch_time_counter_pkg.sv
// Shared constants, types and helpers for the stopwatch/timer time-keeping datapath.
package watch_pkg;

  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 6;
  localparam int BCD_W   = DIGIT_W * DIGITS;

  typedef logic [BCD_W-1:0]   bcd_t;
  typedef logic [DIGIT_W-1:0] digit_t;

  // Per-digit maximum, index 0 = hundredths ... index 5 = tens of minutes.
  localparam digit_t DIGIT_MAX [DIGITS] = '{4'd9, 4'd9, 4'd9, 4'd5, 4'd9, 4'd5};

  localparam bcd_t BCD_ZERO = 24'h000000;
  localparam bcd_t BCD_ONE  = 24'h000001;
  localparam bcd_t BCD_MAX  = 24'h595999;

  // Saturate a preset digit to the largest legal value for its position.
  function automatic digit_t clamp_digit(input digit_t v, input digit_t mx);
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/watch_time_counter_if.sv
// Control strobes in, BCD display and status pulses out.
interface watch_time_counter_if;

  logic            clken;
  logic            rst;
  logic            load;
  logic            mode;
  logic            lap_trigger;
  watch_pkg::bcd_t load_value;
  watch_pkg::bcd_t disp;
  logic            lap_active;
  logic            timer_done;
  logic            wrap;

  modport master (
    output clken, rst, load, mode, lap_trigger, load_value,
    input  disp, lap_active, timer_done, wrap
  );

  modport slave (
    input  clken, rst, load, mode, lap_trigger, load_value,
    output disp, lap_active, timer_done, wrap
  );

endinterface

// File: rtl/watch_time_counter_bcd_digit.sv
// One BCD digit with clear, clamped load and up/down step; chained via carry/borrow.
module bcd_digit
  import watch_pkg::*;
#(
  parameter digit_t MAX = 4'd9
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   clr,
  input  logic   ld,
  input  logic   en,
  input  logic   up,
  input  digit_t ld_val,
  output digit_t q,
  output logic   carry,
  output logic   borrow
);

  digit_t q_d;
  digit_t q_q;

  // carry: this digit wraps on an up-step; borrow: it wraps on a down-step.
  assign carry  = up & (q_q == MAX);
  assign borrow = ~up & (q_q == 4'd0);
  assign q      = q_q;

  // Next digit value: clear beats load beats step.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (ld) begin
      q_d = clamp_digit(ld_val, MAX);
    end else if (en) begin
      if (up) begin
        q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
      end else begin
        q_d = (q_q == 4'd0) ? MAX : q_q - 4'd1;
      end
    end else begin
      q_d = q_q;
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/watch_time_counter.sv
// Time-keeping datapath: 1/100 s divider, six chained BCD digits, lap freeze, done/wrap pulses.
module watch_time_counter
  import watch_pkg::*;
#(
  parameter int TICK_DIV = 250000
) (
  input logic                 clk,
  input logic                 reset,
  watch_time_counter_if.slave bus
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_d, div_q;
  bcd_t             lap_d, lap_q;
  logic             lap_active_d, lap_active_q;
  logic             done_d, done_q;
  logic             wrap_d, wrap_q;

  logic              tick_s;
  logic              step_s;
  bcd_t              count_s;
  digit_t            digit_s  [DIGITS];
  logic [DIGITS-1:0] carry_s;
  logic [DIGITS-1:0] borrow_s;
  logic [DIGITS-1:0] en_s;

  // The tick cycle is suppressed by clear or load; a countdown parked at zero never steps.
  assign tick_s = bus.clken & ~bus.rst & ~bus.load & (div_q == DIV_LAST);
  assign step_s = tick_s & (bus.mode | (count_s != BCD_ZERO));

  // Divider: free-runs while enabled, restarts on clear or load.
  always_comb begin
    div_d = div_q;
    if (bus.rst || bus.load) begin
      div_d = '0;
    end else if (bus.clken) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end else begin
      div_d = div_q;
    end
  end

  // Ripple enable: a digit steps only when every lower digit wraps in the current direction.
  always_comb begin
    en_s = '0;
    en_s[0] = step_s;
    for (int k = 1; k < DIGITS; k++) begin
      en_s[k] = en_s[k-1] & (carry_s[k-1] | borrow_s[k-1]);
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit #(.MAX(DIGIT_MAX[g])) u_digit (
        .clk    (clk),
        .reset  (reset),
        .clr    (bus.rst),
        .ld     (bus.load),
        .en     (en_s[g]),
        .up     (bus.mode),
        .ld_val (bus.load_value[g*DIGIT_W +: DIGIT_W]),
        .q      (digit_s[g]),
        .carry  (carry_s[g]),
        .borrow (borrow_s[g])
      );
    end
  endgenerate

  // Reassemble the packed BCD count from the digit chain.
  always_comb begin
    count_s = BCD_ZERO;
    for (int k = 0; k < DIGITS; k++) begin
      count_s[k*DIGIT_W +: DIGIT_W] = digit_s[k];
    end
  end

  // Lap toggle: first trigger freezes the pre-update count, second releases it.
  always_comb begin
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    if (bus.rst) begin
      lap_d        = BCD_ZERO;
      lap_active_d = 1'b0;
    end else if (bus.lap_trigger) begin
      if (lap_active_q) begin
        lap_active_d = 1'b0;
      end else begin
        lap_d        = count_s;
        lap_active_d = 1'b1;
      end
    end else begin
      lap_active_d = lap_active_q;
    end
  end

  // Limit pulses: decided from the pre-step count so they line up with the update to zero.
  always_comb begin
    done_d = 1'b0;
    wrap_d = 1'b0;
    if (step_s) begin
      if (bus.mode) begin
        wrap_d = (count_s == BCD_MAX);
      end else begin
        done_d = (count_s == BCD_ONE);
      end
    end else begin
      done_d = 1'b0;
      wrap_d = 1'b0;
    end
  end

  // State registers for divider, lap hold and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      lap_q        <= BCD_ZERO;
      lap_active_q <= 1'b0;
      done_q       <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      div_q        <= div_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      done_q       <= done_d;
      wrap_q       <= wrap_d;
    end
  end

  assign bus.disp       = lap_active_q ? lap_q : count_s;
  assign bus.lap_active = lap_active_q;
  assign bus.timer_done = done_q;
  assign bus.wrap       = wrap_q;

endmodule
